// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operations, result selects and
// the control bundle carried from decode into execute.
package rv32i_pkg;

    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcImm    = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluSll   = 4'd2,
        AluSlt   = 4'd3,
        AluSltu  = 4'd4,
        AluXor   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluOr    = 4'd8,
        AluAnd   = 4'd9,
        AluPassB = 4'd10
    } alu_ctrl_t;

    localparam logic [1:0] ResAlu = 2'b00;
    localparam logic [1:0] ResMem = 2'b01;
    localparam logic [1:0] ResPc4 = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       alu_src;
        logic       alu_a_pc;
        alu_ctrl_t  alu_ctrl;
        logic [2:0] funct3;
    } ctrl_t;

    // sub selects SUB for funct3=000; sra selects SRA for funct3=101.
    function automatic alu_ctrl_t alu_decode(logic [2:0] funct3, logic sub, logic sra);
        alu_ctrl_t op;
        case (funct3)
            3'b000:  op = sub ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = sra ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 integer register file: two combinational read ports with write-through
// bypass, one write port, x0 hard-wired to zero.
module register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Same-cycle writeback is forwarded so decode sees the value being written.
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        if (raddr1 == 5'd0) begin
            rdata1 = '0;
        end else if (we && (waddr == raddr1)) begin
            rdata1 = wdata;
        end
        if (raddr2 == 5'd0) begin
            rdata2 = '0;
        end else if (we && (waddr == raddr2)) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: decodes instr_d, reads the register file and loads the
// ID/EX pipeline register; flush_e turns the load into a bubble.
module decode_cycle
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_d,
    input  logic [31:0] pc_d,
    input  logic [31:0] pc_4_d,
    input  logic        flush_e,
    input  logic        reg_write_w,
    input  logic [4:0]  rd_w,
    input  logic [31:0] result_w,
    output logic [31:0] rd1_e,
    output logic [31:0] rd2_e,
    output logic [31:0] imm_e,
    output logic [31:0] pc_e,
    output logic [31:0] pc_4_e,
    output logic [4:0]  rs1_e,
    output logic [4:0]  rs2_e,
    output logic [4:0]  rd_e,
    output ctrl_t       ctrl_e
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        alt;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rd1_d, rd2_d, imm_d;
    ctrl_t       ctrl_d;

    assign opcode = instr_d[6:0];
    assign rd     = instr_d[11:7];
    assign funct3 = instr_d[14:12];
    assign rs1    = instr_d[19:15];
    assign rs2    = instr_d[24:20];
    assign alt    = instr_d[30];

    assign imm_i = {{20{instr_d[31]}}, instr_d[31:20]};
    assign imm_s = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
    assign imm_b = {{20{instr_d[31]}}, instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
    assign imm_u = {instr_d[31:12], 12'b0};
    assign imm_j = {{12{instr_d[31]}}, instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};

    register_file u_register_file (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rd1_d),
        .rdata2 (rd2_d),
        .we     (reg_write_w),
        .waddr  (rd_w),
        .wdata  (result_w)
    );

    // Unknown opcodes fall through to an all-zero control bundle (bubble).
    always_comb begin
        ctrl_d = '0;
        imm_d  = '0;
        case (opcode)
            OpcR: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_ctrl  = alu_decode(funct3, alt, alt);
                ctrl_d.funct3    = funct3;
            end
            OpcImm: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.alu_ctrl  = alu_decode(funct3, 1'b0, alt);
                ctrl_d.funct3    = funct3;
                imm_d            = imm_i;
            end
            OpcLoad: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.result_src = ResMem;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.alu_ctrl   = AluAdd;
                ctrl_d.funct3     = funct3;
                imm_d             = imm_i;
            end
            OpcStore: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.alu_ctrl  = AluAdd;
                ctrl_d.funct3    = funct3;
                imm_d            = imm_s;
            end
            OpcBranch: begin
                ctrl_d.branch   = 1'b1;
                ctrl_d.alu_ctrl = AluSub;
                ctrl_d.funct3   = funct3;
                imm_d           = imm_b;
            end
            OpcJal: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.jump       = 1'b1;
                ctrl_d.result_src = ResPc4;
                imm_d             = imm_j;
            end
            OpcJalr: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.jump       = 1'b1;
                ctrl_d.jalr       = 1'b1;
                ctrl_d.result_src = ResPc4;
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.alu_ctrl   = AluAdd;
                ctrl_d.funct3     = funct3;
                imm_d             = imm_i;
            end
            OpcLui: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.alu_ctrl  = AluPassB;
                imm_d            = imm_u;
            end
            OpcAuipc: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.alu_a_pc  = 1'b1;
                ctrl_d.alu_ctrl  = AluAdd;
                imm_d            = imm_u;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush_e) begin
            rd1_e  <= '0;
            rd2_e  <= '0;
            imm_e  <= '0;
            pc_e   <= '0;
            pc_4_e <= '0;
            rs1_e  <= '0;
            rs2_e  <= '0;
            rd_e   <= '0;
            ctrl_e <= '0;
        end else begin
            rd1_e  <= rd1_d;
            rd2_e  <= rd2_d;
            imm_e  <= imm_d;
            pc_e   <= pc_d;
            pc_4_e <= pc_4_d;
            rs1_e  <= rs1;
            rs2_e  <= rs2;
            rd_e   <= rd;
            ctrl_e <= ctrl_d;
        end
    end

endmodule

// File: tb/tb_decode_cycle.sv
// Self-checking bench for decode_cycle: directed scenarios plus randomized
// instructions compared against a behavioural decode/register-file model.
module tb_decode_cycle;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_d, pc_d, pc_4_d, result_w;
    logic        flush_e, reg_write_w;
    logic [4:0]  rd_w;
    logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc_4_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    ctrl_t       ctrl_e;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        ctrl_t       ctrl;
    } out_t;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] rf_model [32];
    out_t        exp_out;
    out_t        got;

    decode_cycle dut (
        .clk         (clk),
        .rst         (rst),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_4_d      (pc_4_d),
        .flush_e     (flush_e),
        .reg_write_w (reg_write_w),
        .rd_w        (rd_w),
        .result_w    (result_w),
        .rd1_e       (rd1_e),
        .rd2_e       (rd2_e),
        .imm_e       (imm_e),
        .pc_e        (pc_e),
        .pc_4_e      (pc_4_e),
        .rs1_e       (rs1_e),
        .rs2_e       (rs2_e),
        .rd_e        (rd_e),
        .ctrl_e      (ctrl_e)
    );

    always #5 clk = ~clk;

    function automatic out_t dut_out();
        return {rd1_e, rd2_e, imm_e, pc_e, pc_4_e, rs1_e, rs2_e, rd_e, ctrl_e};
    endfunction

    function automatic logic [31:0] model_read(logic [4:0] a, logic we, logic [4:0] wa,
                                               logic [31:0] wd);
        if (a == 0) return 32'd0;
        if (we && wa == a) return wd;
        return rf_model[a];
    endfunction

    function automatic logic [31:0] model_imm(logic [31:0] ins);
        logic signed [11:0] i12 = ins[31:20];
        logic signed [11:0] s12 = {ins[31:25], ins[11:7]};
        logic signed [12:0] b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        logic signed [20:0] j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        case (ins[6:0])
            OpcImm, OpcLoad, OpcJalr: return 32'(i12);
            OpcStore:                 return 32'(s12);
            OpcBranch:                return 32'(b13);
            OpcJal:                   return 32'(j21);
            OpcLui, OpcAuipc:         return ins[31:12] * 32'd4096;
            default:                  return 32'd0;
        endcase
    endfunction

    function automatic ctrl_t model_ctrl(logic [31:0] ins);
        ctrl_t      c = '0;
        alu_ctrl_t  f3_op [8] = '{AluAdd, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluOr, AluAnd};
        logic [2:0] f3 = ins[14:12];
        case (ins[6:0])
            OpcR: begin
                c.reg_write = 1; c.funct3 = f3; c.alu_ctrl = f3_op[f3];
                if (ins[30] && f3 == 0) c.alu_ctrl = AluSub;
                if (ins[30] && f3 == 5) c.alu_ctrl = AluSra;
            end
            OpcImm: begin
                c.reg_write = 1; c.alu_src = 1; c.funct3 = f3; c.alu_ctrl = f3_op[f3];
                if (ins[30] && f3 == 5) c.alu_ctrl = AluSra;
            end
            OpcLoad:   begin c.reg_write = 1; c.result_src = 2'b01; c.alu_src = 1; c.funct3 = f3; end
            OpcStore:  begin c.mem_write = 1; c.alu_src = 1; c.funct3 = f3; end
            OpcBranch: begin c.branch = 1; c.alu_ctrl = AluSub; c.funct3 = f3; end
            OpcJal:    begin c.reg_write = 1; c.jump = 1; c.result_src = 2'b10; end
            OpcJalr: begin
                c.reg_write = 1; c.jump = 1; c.jalr = 1; c.result_src = 2'b10;
                c.alu_src = 1; c.funct3 = f3;
            end
            OpcLui:    begin c.reg_write = 1; c.alu_src = 1; c.alu_ctrl = AluPassB; end
            OpcAuipc:  begin c.reg_write = 1; c.alu_src = 1; c.alu_a_pc = 1; end
            default: ;
        endcase
        return c;
    endfunction

    // Drives one cycle, predicts the ID/EX contents, then samples 1 time unit after the edge.
    task automatic apply(input logic [31:0] ins, input logic fl, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd);
        logic [31:0] pc = $urandom & 32'hFFFF_FFFC;
        instr_d = ins; pc_d = pc; pc_4_d = pc + 4; flush_e = fl;
        reg_write_w = we; rd_w = wa; result_w = wd;
        if (fl) begin
            exp_out = '0;
        end else begin
            exp_out = {model_read(ins[19:15], we, wa, wd), model_read(ins[24:20], we, wa, wd),
                       model_imm(ins), pc, pc + 32'd4, ins[19:15], ins[24:20], ins[11:7],
                       model_ctrl(ins)};
        end
        @(posedge clk);
        #1;
        if (we && wa != 0) rf_model[wa] = wd;
        reg_write_w = 0;
        got = dut_out();
    endtask

    task automatic test_reset();
        rst = 1; instr_d = 32'h0052_8313; pc_d = 32'h100; pc_4_d = 32'h104; flush_e = 0;
        reg_write_w = 1; rd_w = 5'd3; result_w = 32'h55;
        for (int i = 0; i < 32; i++) rf_model[i] = '0;
        #1;
        n_checks++;
        if (dut_out() !== '0) $display("FAIL reset_async got=%h want=0", dut_out());
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (dut_out() !== '0) $display("FAIL reset_hold got=%h want=0", dut_out());
        else n_pass++;
        @(negedge clk);
        rst = 0; reg_write_w = 0;
    endtask

    task automatic test_addi();
        apply(32'h0000_0000, 0, 1, 5'd5, 32'h1234_5678);
        apply(32'h0052_8313, 0, 0, 5'd0, 32'h0);
        n_checks++;
        if (rd1_e !== 32'h1234_5678 || imm_e !== 32'd5 || rd_e !== 5'd6 ||
            ctrl_e.alu_ctrl !== AluAdd || ctrl_e.alu_src !== 1'b1 || ctrl_e.reg_write !== 1'b1)
            $display("FAIL addi got rd1=%h imm=%h rd=%0d alu=%0d src=%b rw=%b want 12345678/5/6/0/1/1",
                     rd1_e, imm_e, rd_e, ctrl_e.alu_ctrl, ctrl_e.alu_src, ctrl_e.reg_write);
        else n_pass++;
        n_checks++;
        if (got !== exp_out) $display("FAIL addi_full got=%h want=%h", got, exp_out);
        else n_pass++;
    endtask

    task automatic test_bypass();
        apply(32'h0003_8433, 0, 1, 5'd7, 32'h0000_DEAD);
        n_checks++;
        if (rd1_e !== 32'h0000_DEAD || rd2_e !== 32'd0 || rd_e !== 5'd8)
            $display("FAIL bypass got rd1=%h rd2=%h rd=%0d want 0000dead/0/8", rd1_e, rd2_e, rd_e);
        else n_pass++;
    endtask

    task automatic test_x0();
        apply(32'h0000_0093, 0, 1, 5'd0, 32'hFFFF_FFFF);
        n_checks++;
        if (rd1_e !== 32'd0) $display("FAIL x0_same_cycle got=%h want=0", rd1_e);
        else n_pass++;
        apply(32'h0000_0093, 0, 0, 5'd0, 32'h0);
        n_checks++;
        if (rd1_e !== 32'd0) $display("FAIL x0_read got=%h want=0", rd1_e);
        else n_pass++;
    endtask

    task automatic test_beq();
        apply(32'hFE00_0EE3, 0, 0, 5'd0, 32'h0);
        n_checks++;
        if (imm_e !== 32'hFFFF_FFFC || ctrl_e.branch !== 1'b1 || ctrl_e.alu_ctrl !== AluSub ||
            ctrl_e.reg_write !== 1'b0)
            $display("FAIL beq got imm=%h br=%b alu=%0d rw=%b want fffffffc/1/1/0",
                     imm_e, ctrl_e.branch, ctrl_e.alu_ctrl, ctrl_e.reg_write);
        else n_pass++;
    endtask

    task automatic test_flush();
        apply(32'h0080_00EF, 0, 0, 5'd0, 32'h0);
        n_checks++;
        if (ctrl_e.jump !== 1'b1 || ctrl_e.result_src !== 2'b10 || ctrl_e.reg_write !== 1'b1 ||
            imm_e !== 32'd8)
            $display("FAIL jal got jump=%b rs=%b rw=%b imm=%h want 1/10/1/8",
                     ctrl_e.jump, ctrl_e.result_src, ctrl_e.reg_write, imm_e);
        else n_pass++;
        apply(32'h0080_00EF, 1, 1, 5'd9, 32'hCAFE_F00D);
        n_checks++;
        if (got !== '0) $display("FAIL flush_bubble got=%h want=0", got);
        else n_pass++;
        apply(32'h0004_8513, 0, 0, 5'd0, 32'h0);
        n_checks++;
        if (rd1_e !== 32'hCAFE_F00D) $display("FAIL flush_wb got=%h want=cafef00d", rd1_e);
        else n_pass++;
    endtask

    task automatic test_illegal_and_reset();
        apply(32'h0000_007F, 0, 0, 5'd0, 32'h0);
        n_checks++;
        if (ctrl_e !== '0) $display("FAIL illegal_ctrl got=%h want=0", ctrl_e);
        else n_pass++;
        apply(32'h0004_8513, 0, 0, 5'd0, 32'h0);
        #2 rst = 1;
        #1;
        n_checks++;
        if (dut_out() !== '0) $display("FAIL reset_mid got=%h want=0", dut_out());
        else n_pass++;
        for (int i = 0; i < 32; i++) rf_model[i] = '0;
        @(negedge clk);
        rst = 0;
        apply(32'h0004_8513, 0, 0, 5'd0, 32'h0);
        n_checks++;
        if (got !== exp_out || rd1_e !== 32'd0)
            $display("FAIL reset_first_load got=%h want=%h", got, exp_out);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [6:0] ops [10] = '{OpcR, OpcImm, OpcLoad, OpcStore, OpcBranch, OpcJal, OpcJalr,
                                 OpcLui, OpcAuipc, 7'h0};
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins = $urandom;
            int unsigned k = $urandom_range(0, 9);
            if (k < 9) ins[6:0] = ops[k];
            apply(ins, ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1),
                  5'($urandom_range(0, 31)), $urandom);
            n_checks++;
            if (got !== exp_out)
                $display("FAIL random[%0d] instr=%h got=%h want=%h", i, ins, got, exp_out);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_bypass();
        test_x0();
        test_beq();
        test_flush();
        test_illegal_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
